// File: rtl/salu_pkg.sv
// Shared types and constants for the SALU divider slice.
// Holds the divider FSM state type, the ALU operation selects and a counter-width helper.
package salu_pkg;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} div_state_t;

    localparam logic SEL_ADD = 1'b0;
    localparam logic SEL_SUB = 1'b1;

    // The iteration counter counts WIDTH-1 down to 0.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/salu_divider_alu.sv
// simple_alu: unsigned add/subtract datapath shared by the SALU blocks.
// o_uf flags a borrow on subtract, o_of flags a carry out on add.
module simple_alu
    import salu_pkg::*;
#(
    parameter int WIDTH = 10
)
(
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_sel,
    output logic [WIDTH-1:0] o_out,
    output logic             o_uf,
    output logic             o_of
);

    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH:0]   w_sum;

    // Subtract is a + ~b + 1; its carry out is set exactly when a >= b.
    always_comb begin
        w_b_eff = (i_sel == SEL_SUB) ? ~i_b : i_b;
        w_sum   = {1'b0, i_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, i_sel};
        o_out   = w_sum[WIDTH-1:0];
        o_uf    = (i_sel == SEL_SUB) && !w_sum[WIDTH];
        o_of    = (i_sel == SEL_ADD) && w_sum[WIDTH];
    end

endmodule

// File: rtl/salu_divider.sv
// salu_divider: sequential unsigned restoring divider, one trial subtraction per cycle.
// Define SALU_DIV_EARLY_EXIT_EN to finish in one edge when dividend < divisor.
module salu_divider
    import salu_pkg::*;
#(
    parameter int WIDTH = 9
)
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_div_valid,
    output logic             o_div_ready,
    input  logic [WIDTH-1:0] i_div_dividend,
    input  logic [WIDTH-1:0] i_div_divisor,
    output logic             o_div_valid,
    input  logic             i_div_ready,
    output logic [WIDTH-1:0] o_div_quotient,
    output logic [WIDTH-1:0] o_div_remainder,
    output logic             o_div_dbz
);

    localparam int CW = cnt_width(WIDTH);

    div_state_t       r_state;
    div_state_t       w_state_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_q_out;
    logic [WIDTH-1:0] r_r_out;
    logic             r_dbz;

    logic [WIDTH:0]   w_alu_a;
    logic [WIDTH:0]   w_alu_b;
    logic [WIDTH:0]   w_alu_diff;
    logic             w_alu_uf;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_quo_next;
    logic             w_div_zero;
    logic             w_accept;

    // With early exit, the idle subtractor compares the incoming operands instead of idling.
    always_comb begin
`ifdef SALU_DIV_EARLY_EXIT_EN
        if (r_state == S_CALC) begin
            w_alu_a = {r_rem, r_quo[WIDTH-1]};
            w_alu_b = {1'b0, r_dvs};
        end else begin
            w_alu_a = {1'b0, i_div_dividend};
            w_alu_b = {1'b0, i_div_divisor};
        end
`else
        w_alu_a = {r_rem, r_quo[WIDTH-1]};
        w_alu_b = {1'b0, r_dvs};
`endif
        w_rem_next = w_alu_uf ? w_alu_a[WIDTH-1:0] : w_alu_diff[WIDTH-1:0];
        w_quo_next = {r_quo[WIDTH-2:0], ~w_alu_uf};
        w_div_zero = (i_div_divisor == '0);
        w_accept   = (r_state == S_IDLE) && i_div_valid;
    end

    simple_alu #(.WIDTH(WIDTH + 1)) u_alu (
        .i_a   (w_alu_a),
        .i_b   (w_alu_b),
        .i_sel (SEL_SUB),
        .o_out (w_alu_diff),
        .o_uf  (w_alu_uf),
        .o_of  ()
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (i_div_valid) begin
                    if (w_div_zero) begin
                        w_state_next = S_DONE;
                    end
`ifdef SALU_DIV_EARLY_EXIT_EN
                    else if (w_alu_uf) begin
                        w_state_next = S_DONE;
                    end
`endif
                    else begin
                        w_state_next = S_CALC;
                    end
                end
            end
            S_CALC:  if (r_cnt == '0) w_state_next = S_DONE;
            S_DONE:  if (i_div_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Result registers change only on accept (short paths) or on the final iteration.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_dvs   <= '0;
            r_q_out <= '0;
            r_r_out <= '0;
            r_dbz   <= 1'b0;
        end else if (w_accept) begin
            r_dvs <= i_div_divisor;
            if (w_div_zero) begin
                r_q_out <= '1;
                r_r_out <= i_div_dividend;
                r_dbz   <= 1'b1;
            end
`ifdef SALU_DIV_EARLY_EXIT_EN
            else if (w_alu_uf) begin
                r_q_out <= '0;
                r_r_out <= i_div_dividend;
                r_dbz   <= 1'b0;
            end
`endif
            else begin
                r_rem <= '0;
                r_quo <= i_div_dividend;
                r_cnt <= CW'(WIDTH - 1);
                r_dbz <= 1'b0;
            end
        end else if (r_state == S_CALC) begin
            r_rem <= w_rem_next;
            r_quo <= w_quo_next;
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == '0) begin
                r_q_out <= w_quo_next;
                r_r_out <= w_rem_next;
            end
        end
    end

    assign o_div_ready     = (r_state == S_IDLE);
    assign o_div_valid     = (r_state == S_DONE);
    assign o_div_quotient  = r_q_out;
    assign o_div_remainder = r_r_out;
    assign o_div_dbz       = r_dbz;

endmodule

// File: tb/tb_salu_divider.sv
// Self-checking bench for salu_divider (WIDTH=9): directed vector table, corner sequences, random sweep.
// Latency expectations follow SALU_DIV_EARLY_EXIT_EN when the bench is built with it.
module tb_salu_divider;

    localparam int WIDTH      = 9;
    localparam int EDGE_LIMIT = 40;
    localparam int NUM_VEC    = 10;
    localparam int NUM_RAND   = 300;

    typedef struct {
        logic [WIDTH-1:0] dividend;
        logic [WIDTH-1:0] divisor;
        logic [WIDTH-1:0] expQuo;
        logic [WIDTH-1:0] expRem;
        logic             expDbz;
        int               holdCycles;
    } divVector_t;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             iDivValid = 1'b0;
    logic             iDivReady = 1'b0;
    logic [WIDTH-1:0] iDivDividend = '0;
    logic [WIDTH-1:0] iDivDivisor = '0;
    logic             oDivReady;
    logic             oDivValid;
    logic [WIDTH-1:0] oDivQuotient;
    logic [WIDTH-1:0] oDivRemainder;
    logic             oDivDbz;

    int checkCount = 0;
    int errorCount = 0;
    divVector_t vectors [NUM_VEC];

    salu_divider #(.WIDTH(WIDTH)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .i_div_valid     (iDivValid),
        .o_div_ready     (oDivReady),
        .i_div_dividend  (iDivDividend),
        .i_div_divisor   (iDivDivisor),
        .o_div_valid     (oDivValid),
        .i_div_ready     (iDivReady),
        .o_div_quotient  (oDivQuotient),
        .o_div_remainder (oDivRemainder),
        .o_div_dbz       (oDivDbz)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Edges after the accepting edge until o_div_valid is seen.
    function automatic int expectedLatency(input logic [WIDTH-1:0] dividend, input logic [WIDTH-1:0] divisor);
        if (divisor == '0) return 0;
`ifdef SALU_DIV_EARLY_EXIT_EN
        if (dividend < divisor) return 0;
`endif
        return WIDTH;
    endfunction

    task automatic pulseReset();
        @(negedge clk);
        reset_n = 1'b0;
        iDivValid = 1'b0;
        iDivReady = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Present one operand pair, then wait (bounded) for the result while scrambling the dividend.
    task automatic applyStimulus(input logic [WIDTH-1:0] dividend, input logic [WIDTH-1:0] divisor,
                                 output int edges, output bit timedOut, output bit readyStayedLow);
        @(negedge clk);
        iDivValid    = 1'b1;
        iDivDividend = dividend;
        iDivDivisor  = divisor;
        iDivReady    = 1'b0;
        @(posedge clk);
        #1;
        iDivValid    = 1'b0;
        iDivDividend = ~dividend;
        edges = 0;
        readyStayedLow = 1'b1;
        while (!oDivValid && edges < EDGE_LIMIT) begin
            if (oDivReady) readyStayedLow = 1'b0;
            @(posedge clk);
            #1;
            edges++;
            iDivDividend = WIDTH'($urandom);
        end
        timedOut = !oDivValid;
    endtask

    task automatic releaseResult(input string tag, input logic [WIDTH-1:0] expQuo);
        @(negedge clk);
        iDivReady = 1'b1;
        @(posedge clk);
        #1;
        iDivReady = 1'b0;
        checkOutput({tag, " back to idle"}, {oDivValid, oDivReady}, 32'd1);
        checkOutput({tag, " quotient retained"}, oDivQuotient, expQuo);
    endtask

    task automatic runCase(input string tag, input divVector_t v);
        int  edges;
        bit  timedOut;
        bit  readyLow;
        int  expLat;
        expLat = expectedLatency(v.dividend, v.divisor);
        applyStimulus(v.dividend, v.divisor, edges, timedOut, readyLow);
        if (timedOut) begin
            checkOutput({tag, " timeout"}, 32'(edges), 32'(expLat));
            pulseReset();
            return;
        end
        checkOutput({tag, " latency"}, 32'(edges), 32'(expLat));
        if (expLat > 0) checkOutput({tag, " ready low in calc"}, readyLow, 1);
        checkOutput({tag, " quotient"}, oDivQuotient, v.expQuo);
        checkOutput({tag, " remainder"}, oDivRemainder, v.expRem);
        checkOutput({tag, " dbz"}, oDivDbz, v.expDbz);
        for (int h = 0; h < v.holdCycles; h++) begin
            @(posedge clk);
            #1;
            checkOutput({tag, " backpressure hold"},
                        {oDivValid, oDivReady, oDivDbz, oDivQuotient, oDivRemainder},
                        {1'b1, 1'b0, v.expDbz, v.expQuo, v.expRem});
        end
        releaseResult(tag, v.expQuo);
    endtask

    initial begin
        int  edges;
        bit  timedOut;
        bit  readyLow;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] eq;
        logic [WIDTH-1:0] er;

        vectors[0] = '{9'd100, 9'd7,   9'd14,  9'd2,   1'b0, 5};
        vectors[1] = '{9'd511, 9'd1,   9'd511, 9'd0,   1'b0, 0};
        vectors[2] = '{9'd9,   9'd3,   9'd3,   9'd0,   1'b0, 0};
        vectors[3] = '{9'd510, 9'd511, 9'd0,   9'd510, 1'b0, 0};
        vectors[4] = '{9'd5,   9'd0,   9'd511, 9'd5,   1'b1, 2};
        vectors[5] = '{9'd8,   9'd4,   9'd2,   9'd0,   1'b0, 0};
        vectors[6] = '{9'd3,   9'd200, 9'd0,   9'd3,   1'b0, 0};
        vectors[7] = '{9'd0,   9'd5,   9'd0,   9'd0,   1'b0, 0};
        vectors[8] = '{9'd0,   9'd0,   9'd511, 9'd0,   1'b1, 0};
        vectors[9] = '{9'd200, 9'd13,  9'd15,  9'd5,   1'b0, 1};

        #12;
        checkOutput("reset ready/valid", {oDivReady, oDivValid}, 32'd2);
        checkOutput("reset outputs", {oDivDbz, oDivQuotient, oDivRemainder}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < NUM_VEC; i++) begin
            runCase($sformatf("vec%0d %0d/%0d", i, vectors[i].dividend, vectors[i].divisor), vectors[i]);
        end

        // Abort in the middle of an iteration sequence, then divide again.
        @(negedge clk);
        iDivValid = 1'b1;
        iDivDividend = 9'd100;
        iDivDivisor = 9'd7;
        @(posedge clk);
        #1;
        iDivValid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        checkOutput("abort ready/valid", {oDivReady, oDivValid}, 32'd2);
        checkOutput("abort outputs", {oDivDbz, oDivQuotient, oDivRemainder}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        checkOutput("abort no result", {oDivReady, oDivValid}, 32'd2);
        runCase("after abort 200/13", vectors[9]);

        // Random sweep against the / and % model; stops at the first wrong result.
        for (int n = 0; n < NUM_RAND; n++) begin
            a = WIDTH'($urandom);
            b = (n % 16 == 0) ? '0 : WIDTH'($urandom_range(0, 511) >> $urandom_range(0, 8));
            eq = (b == '0) ? '1 : a / b;
            er = (b == '0) ? a : a % b;
            applyStimulus(a, b, edges, timedOut, readyLow);
            checkCount++;
            if (timedOut || oDivQuotient !== eq || oDivRemainder !== er || oDivDbz !== (b == '0)) begin
                errorCount++;
                $display("[TB] FAIL sweep %0d/%0d: got q=%0d r=%0d dbz=%0d, expected q=%0d r=%0d dbz=%0d",
                         a, b, oDivQuotient, oDivRemainder, oDivDbz, eq, er, (b == '0));
                break;
            end
            @(negedge clk);
            iDivReady = 1'b1;
            @(posedge clk);
            #1;
            iDivReady = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
